// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for a MIPS-subset datapath (lw, sw, addi, beq, bne, R-type, j).
// It steps one shared ALU and one unified memory through the fetch/decode/execute phases.
// It also drives the datapath selects and the req/ready memory handshake.
// A stalled memory access or an unknown opcode traps the controller until reset.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       alusrc_a_o,
  output logic [1:0] alusrc_b_o,
  output logic [1:0] aluop_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       reg_write_o,
  output logic       retire_o,
  output logic       trap_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_MEMADDR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_RWB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of completed ready-less request cycles of the current access.
  // Once it reaches MEM_TIMEOUT, one more cycle without ready sends the FSM to TRAP.
  // A ready in that same cycle still completes the access.
  logic at_limit;
  assign at_limit = (cnt_q == CNT_LIMIT);

  // State, latched opcode and timeout counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      opcode_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic and per-state datapath controls (Mealy only where ready or zero matter).
  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path infers a latch
    // and unselected mux controls are driven 0.
    state_d     = state_q;
    opcode_d    = opcode_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    iord_o      = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = 2'b00;
    alusrc_a_o  = 1'b0;
    alusrc_b_o  = 2'b00;
    aluop_o     = 2'b00;
    regdst_o    = 1'b0;
    memtoreg_o  = 1'b0;
    reg_write_o = 1'b0;
    retire_o    = 1'b0;
    trap_o      = 1'b0;

    case (state_q)
      S_INIT: state_d = S_FETCH;

      S_FETCH: begin
        mem_req_o  = 1'b1;
        alusrc_b_o = 2'b01;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (at_limit) begin
          state_d = S_TRAP;
        end
      end

      S_DECODE: begin
        opcode_d   = opcode_i;
        alusrc_b_o = 2'b11;
        case (opcode_i)
          OP_LW, OP_SW:      state_d = S_MEMADDR;
          OP_RTYPE, OP_ADDI: state_d = S_EXEC;
          OP_BEQ, OP_BNE:    state_d = S_BRANCH;
          OP_J:              state_d = S_JUMP;
          default:           state_d = S_TRAP;
        endcase
      end

      S_MEMADDR: begin
        alusrc_a_o = 1'b1;
        alusrc_b_o = 2'b10;
        state_d    = (opcode_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) begin
          state_d = S_MEMWB;
        end else if (at_limit) begin
          state_d = S_TRAP;
        end
      end

      S_MEMWB: begin
        reg_write_o = 1'b1;
        memtoreg_o  = 1'b1;
        retire_o    = 1'b1;
        state_d     = S_FETCH;
      end

      S_MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) begin
          retire_o = 1'b1;
          state_d  = S_FETCH;
        end else if (at_limit) begin
          state_d = S_TRAP;
        end
      end

      S_EXEC: begin
        alusrc_a_o = 1'b1;
        if (opcode_q == OP_RTYPE) begin
          aluop_o = 2'b10;
        end else begin
          alusrc_b_o = 2'b10;
        end
        state_d = S_RWB;
      end

      S_RWB: begin
        reg_write_o = 1'b1;
        regdst_o    = (opcode_q == OP_RTYPE);
        retire_o    = 1'b1;
        state_d     = S_FETCH;
      end

      S_BRANCH: begin
        alusrc_a_o = 1'b1;
        aluop_o    = 2'b01;
        pc_src_o   = 2'b01;
        pc_write_o = (opcode_q == OP_BEQ) ? zero_i : ~zero_i;
        retire_o   = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        pc_src_o   = 2'b10;
        pc_write_o = 1'b1;
        retire_o   = 1'b1;
        state_d    = S_FETCH;
      end

      S_TRAP: trap_o = 1'b1;

      default: state_d = S_TRAP;
    endcase

    // The counter runs only while a request waits; any ready or idle cycle clears it.
    // Every access state is therefore entered with a zero count.
    cnt_d = (mem_req_o && !mem_ready_i) ? cnt_q + CNT_W'(1) : '0;
  end

endmodule
